conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_pkg.sv | 23 ++
 rtl/res_fifo2.sv | 55 +++++
 rtl/conv_sequencer.sv | 176 +++++++++++++++++
 tb/tb_conv_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer.
//   ACT_W / ACC_W : activation/weight word width and result word width
//   N_DEF / K_DEF : default feature-map and kernel side lengths
//   CNT_W         : width of the weight, activation and result counters
//   state_e       : sequencer FSM states
package conv_pkg;

   localparam int ACT_W = 16;
   localparam int ACC_W = 32;
   localparam int N_DEF = 10;
   localparam int K_DEF = 3;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LOAD_W,
      S_STREAM,
      S_DRAIN,
      S_FINISH
   } state_e;

endpackage

// File: rtl/res_fifo2.sv
// Two-entry result FIFO between the convolver capture point and the r_* stream.
//   clk, global_rst_n   : clock, async active-low reset (empties and zeroes entries)
//   push, push_data     : write one result (ignored when full)
//   pop                 : remove head entry (ignored when empty)
//   head, empty, full   : head entry and occupancy flags
module res_fifo2
   import conv_pkg::*;
(
   input  logic             clk,
   input  logic             global_rst_n,
   input  logic             push,
   input  logic [ACC_W-1:0] push_data,
   input  logic             pop,
   output logic [ACC_W-1:0] head,
   output logic             empty,
   output logic             full
);

   logic [1:0][ACC_W-1:0] mem_q, mem_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  do_push, do_pop;

   assign empty   = (cnt_q == 2'd0);
   assign full    = (cnt_q == 2'd2);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q ^ do_push;
      rd_ptr_d = rd_ptr_q ^ do_pop;
      cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
      end
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_sequencer.sv
// Frame sequencer for an external KxK convolver over an NxN feature map.
//   clk, global_rst_n            : clock, async active-low reset
//   start                        : frame start pulse (honoured only when idle)
//   w_valid/w_ready/w_data       : kernel weight stream, row-major
//   a_valid/a_ready/a_data       : activation stream, row-major, N*N words
//   r_valid/r_ready/r_data       : result stream out of a 2-entry FIFO
//   conv_rst/conv_ce/conv_act/conv_weight : convolver controls
//   conv_op/conv_valid/conv_end  : convolver outputs
//   busy, done                   : not-idle flag, frame-complete pulse
//
// state    | meaning
// S_IDLE   | waiting for start
// S_CLR    | convolver held in reset for two cycles, counters cleared
// S_LOAD_W | accepting K*K kernel weights
// S_STREAM | forwarding N*N activations while the FIFO has space
// S_DRAIN  | clocking zeros through the convolver until all results are out
// S_FINISH | waiting for the FIFO to empty, then pulsing done
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int K = K_DEF
) (
   input  logic                   clk,
   input  logic                   global_rst_n,
   input  logic                   start,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [ACT_W-1:0]       w_data,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic [ACT_W-1:0]       a_data,
   output logic                   r_valid,
   input  logic                   r_ready,
   output logic [ACC_W-1:0]       r_data,
   output logic                   conv_rst,
   output logic                   conv_ce,
   output logic [ACT_W-1:0]       conv_act,
   output logic [K*K*ACT_W-1:0]   conv_weight,
   input  logic [ACC_W-1:0]       conv_op,
   input  logic                   conv_valid,
   input  logic                   conv_end,
   output logic                   busy,
   output logic                   done
);

   localparam int               KK       = K * K;
   localparam logic [CNT_W-1:0] LAST_W   = CNT_W'(KK - 1);
   localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(N * N - 1);
   localparam logic [CNT_W-1:0] NUM_RES  = CNT_W'((N - K + 1) * (N - K + 1));

   state_e                  state_q, state_d;
   logic                    clr_tmr_q, clr_tmr_d;
   logic [CNT_W-1:0]        widx_q, widx_d;
   logic [CNT_W-1:0]        acnt_q, acnt_d;
   logic [CNT_W-1:0]        rcnt_q, rcnt_d;
   logic [KK*ACT_W-1:0]     wgt_q, wgt_d;

   logic fifo_push, fifo_pop, fifo_empty, fifo_full, space;

   assign space = ~fifo_full;

   always_comb begin
      state_d   = state_q;
      clr_tmr_d = clr_tmr_q;
      widx_d    = widx_q;
      acnt_d    = acnt_q;
      rcnt_d    = rcnt_q;
      wgt_d     = wgt_q;
      w_ready   = 1'b0;
      a_ready   = 1'b0;
      conv_ce   = 1'b0;
      conv_act  = '0;
      done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_CLR;
               clr_tmr_d = 1'b1;
            end
         end
         S_CLR: begin
            widx_d = '0;
            acnt_d = '0;
            rcnt_d = '0;
            if (clr_tmr_q == 1'b0) begin
               state_d = S_LOAD_W;
            end else begin
               clr_tmr_d = clr_tmr_q - 1'b1;
            end
         end
         S_LOAD_W: begin
            w_ready = 1'b1;
            if (w_valid) begin
               for (int i = 0; i < KK; i++) begin
                  if (widx_q == CNT_W'(i)) begin
                     wgt_d[i*ACT_W +: ACT_W] = w_data;
                  end
               end
               widx_d = widx_q + 1'b1;
               if (widx_q == LAST_W) begin
                  state_d = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            conv_ce  = a_valid & space;
            a_ready  = conv_ce;
            conv_act = a_data;
            if (conv_ce) begin
               acnt_d = acnt_q + 1'b1;
               if (acnt_q == LAST_ACT) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            conv_ce = space;
            if ((rcnt_q == NUM_RES) || conv_end) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            if (fifo_empty) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Results beyond the last valid window position are discarded.
      fifo_push = conv_ce & conv_valid & (rcnt_q < NUM_RES);
      if (fifo_push) begin
         rcnt_d = rcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q   <= S_IDLE;
         clr_tmr_q <= 1'b0;
         widx_q    <= '0;
         acnt_q    <= '0;
         rcnt_q    <= '0;
         wgt_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_tmr_q <= clr_tmr_d;
         widx_q    <= widx_d;
         acnt_q    <= acnt_d;
         rcnt_q    <= rcnt_d;
         wgt_q     <= wgt_d;
      end
   end

   // conv_rst follows the reset pin directly so the convolver is held while we are.
   assign conv_rst    = ~global_rst_n | (state_q == S_CLR);
   assign conv_weight = wgt_q;
   assign busy        = (state_q != S_IDLE);
   assign r_valid     = ~fifo_empty;
   assign fifo_pop    = r_valid & r_ready;

   res_fifo2 u_res_fifo2 (
      .clk          (clk),
      .global_rst_n (global_rst_n),
      .push         (fifo_push),
      .push_data    (conv_op),
      .pop          (fifo_pop),
      .head         (r_data),
      .empty        (fifo_empty),
      .full         (fifo_full)
   );

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;
   import conv_pkg::*;

   localparam int N  = 10;
   localparam int K  = 3;
   localparam int KK = K * K;
   localparam int NN = N * N;
   localparam int NR = (N - K + 1) * (N - K + 1);
   localparam int MAX_CYC = 4000;

   logic                 clk;
   logic                 global_rst_n;
   logic                 start;
   logic                 w_valid, w_ready;
   logic [ACT_W-1:0]     w_data;
   logic                 a_valid, a_ready;
   logic [ACT_W-1:0]     a_data;
   logic                 r_valid, r_ready;
   logic [ACC_W-1:0]     r_data;
   logic                 conv_rst, conv_ce;
   logic [ACT_W-1:0]     conv_act;
   logic [KK*ACT_W-1:0]  conv_weight;
   logic [ACC_W-1:0]     conv_op;
   logic                 conv_valid, conv_end;
   logic                 busy, done;

   conv_sequencer #(.N(N), .K(K)) dut (
      .clk          (clk),
      .global_rst_n (global_rst_n),
      .start        (start),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .w_data       (w_data),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_data       (a_data),
      .r_valid      (r_valid),
      .r_ready      (r_ready),
      .r_data       (r_data),
      .conv_rst     (conv_rst),
      .conv_ce      (conv_ce),
      .conv_act     (conv_act),
      .conv_weight  (conv_weight),
      .conv_op      (conv_op),
      .conv_valid   (conv_valid),
      .conv_end     (conv_end),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stand-in for the external convolver: sliding-window sum with a two-stage
   // output pipeline that only advances on conv_ce.
   int unsigned img [NN];
   int          pix;
   logic        pv0, pv1;
   logic [31:0] pd0, pd1;

   always @(posedge clk) begin : conv_model
      logic        nv;
      logic [31:0] nd;
      int          r, c;
      if (conv_rst) begin
         pix = 0;
         pv0 <= 1'b0;
         pv1 <= 1'b0;
         pd0 <= '0;
         pd1 <= '0;
      end else if (conv_ce) begin
         nv = 1'b0;
         nd = '0;
         if (pix < NN) begin
            img[pix] = 32'(conv_act);
            r = pix / N;
            c = pix % N;
            if (r >= K - 1 && c >= K - 1) begin
               nv = 1'b1;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++)
                     nd += 32'(conv_weight[(i*K+j)*16 +: 16]) * img[(r-K+1+i)*N + (c-K+1+j)];
            end
         end
         pix++;
         pv1 <= pv0;
         pd1 <= pd0;
         pv0 <= nv;
         pd0 <= nd;
      end
   end

   assign conv_valid = pv1;
   assign conv_op    = pd1;
   assign conv_end   = 1'b0;

   // Bench-side frame bookkeeping
   int unsigned w_arr [KK];
   int unsigned a_arr [NN];
   int unsigned exp_q [$];
   int          wcount, acount, cap, occ, pops, rst_cnt, done_cnt;
   bit          in_frame;
   int          rr_pct;
   int          amode;
   int          tcyc;

   always @(negedge clk) begin
      if (global_rst_n) begin
         chk("r_valid_vs_occupancy", r_valid, occ > 0);
         if (occ >= 2) chk("ce_while_full", conv_ce, 0);
         if (in_frame) begin
            chk("conv_rst", conv_rst, rst_cnt < 2);
            chk("w_ready", w_ready, (rst_cnt == 2) && (wcount < KK));
            if (rst_cnt == 2 && wcount == KK && acount < NN) begin
               chk("stream_ce", conv_ce, a_valid && (occ < 2));
               chk("stream_a_ready", a_ready, a_valid && (occ < 2));
               if (conv_ce) chk("stream_act", conv_act, a_data);
            end else begin
               chk("a_ready_off", a_ready, 0);
               if (acount == NN && cap < NR) begin
                  chk("drain_ce", conv_ce, occ < 2);
                  chk("drain_act", conv_act, 0);
               end else if (wcount < KK) begin
                  chk("load_ce", conv_ce, 0);
               end
            end
            chk("busy_frame", busy, done_cnt == 0);
            if (done) begin
               chk("done_fifo_empty", occ, 0);
               chk("done_all_results", cap, NR);
            end
         end else begin
            chk("idle_busy", busy, 0);
            chk("idle_conv_rst", conv_rst, 0);
            chk("idle_ce", conv_ce, 0);
            chk("idle_w_ready", w_ready, 0);
            chk("idle_a_ready", a_ready, 0);
            chk("idle_done", done, 0);
         end

         if (conv_rst) rst_cnt++;
         if (w_valid && w_ready) wcount++;
         if (a_valid && a_ready) acount++;
         if (conv_ce && conv_valid && cap < NR) begin
            cap++;
            occ++;
         end
         if (r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL extra_result: got %0d, expected no result (t=%0t)", r_data, $time);
            end else begin
               chk("r_data", r_data, exp_q.pop_front());
            end
            occ--;
            pops++;
         end
         if (done) done_cnt++;
      end
   end

   task automatic build_exp();
      int unsigned s;
      exp_q.delete();
      for (int r = 0; r <= N - K; r++)
         for (int c = 0; c <= N - K; c++) begin
            s = 0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  s += w_arr[i*K+j] * a_arr[(r+i)*N + c + j];
            exp_q.push_back(s);
         end
   endtask

   task automatic clear_counts();
      wcount = 0; acount = 0; cap = 0; occ = 0;
      pops = 0; rst_cnt = 0; done_cnt = 0; tcyc = 0;
   endtask

   task automatic drive_inputs();
      w_valid = (wcount < KK) && (amode != 2 || $urandom_range(0, 99) < 70);
      w_data  = (wcount < KK) ? ACT_W'(w_arr[wcount]) : '0;
      if (acount < NN) begin
         case (amode)
            0:       a_valid = 1'b1;
            1:       a_valid = (tcyc % 7) >= 5;
            default: a_valid = $urandom_range(0, 99) < 70;
         endcase
         a_data = ACT_W'(a_arr[acount]);
      end else begin
         a_valid = 1'b0;
         a_data  = '0;
      end
      r_ready = $urandom_range(0, 99) < rr_pct;
      tcyc++;
   endtask

   task automatic run_frame(input int abort_at, input bit extra_start);
      int cyc;
      bit es_done;
      cyc = 0;
      es_done = 1'b0;
      clear_counts();
      @(posedge clk); #1;
      start = 1'b1;
      drive_inputs();
      @(posedge clk); #1;
      start    = 1'b0;
      in_frame = 1'b1;
      while (done_cnt == 0 && cyc < MAX_CYC) begin
         drive_inputs();
         start = 1'b0;
         if (extra_start && !es_done && acount >= 50) begin
            start   = 1'b1;
            es_done = 1'b1;
         end
         if (abort_at > 0 && acount >= abort_at) begin
            global_rst_n = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_conv_rst", conv_rst, 1);
            chk("abort_r_valid", r_valid, 0);
            chk("abort_ce", conv_ce, 0);
            chk("abort_weight4", conv_weight[4*16 +: 16], 0);
            repeat (2) @(posedge clk);
            #1;
            chk("abort_busy_held", busy, 0);
            in_frame = 1'b0;
            start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
            clear_counts();
            exp_q.delete();
            global_rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; w_valid = 1'b0; a_valid = 1'b0; r_ready = 1'b1;
      if (cyc >= MAX_CYC) begin
         n_checks++;
         n_errors++;
         $display("FAIL frame_timeout: got no done after %0d cycles, expected done", cyc);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt, 1);
      chk("results_popped", pops, NR);
      chk("results_left", exp_q.size(), 0);
      chk("conv_rst_cycles", rst_cnt, 2);
      for (int i = 0; i < KK; i++)
         chk("weight_hold", conv_weight[i*16 +: 16], 32'(w_arr[i][15:0]));
      in_frame = 1'b0;
   endtask

   task automatic ramp_data();
      for (int i = 0; i < KK; i++) w_arr[i] = (i == KK / 2) ? 1 : 0;
      for (int i = 0; i < NN; i++) a_arr[i] = i;
   endtask

   initial begin
      global_rst_n = 1'b0;
      start = 1'b0; w_valid = 1'b0; w_data = '0;
      a_valid = 1'b0; a_data = '0; r_ready = 1'b0;
      rr_pct = 100; amode = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_conv_rst", conv_rst, 1);
      chk("rst_ce", conv_ce, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_data", r_data, 0);
      chk("rst_conv_act", conv_act, 0);
      for (int i = 0; i < KK; i++) chk("rst_weight", conv_weight[i*16 +: 16], 0);
      global_rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Nominal: all ones
      for (int i = 0; i < KK; i++) w_arr[i] = 1;
      for (int i = 0; i < NN; i++) a_arr[i] = 1;
      build_exp();
      chk("pin_nominal_first", exp_q[0], 9);
      chk("pin_nominal_last", exp_q[NR-1], 9);
      chk("pin_nominal_count", exp_q.size(), 64);
      rr_pct = 100; amode = 0;
      run_frame(0, 1'b0);

      // Ramp through the centre tap
      ramp_data();
      build_exp();
      chk("pin_ramp_first", exp_q[0], 11);
      chk("pin_ramp_row1", exp_q[8], 21);
      chk("pin_ramp_last", exp_q[NR-1], 88);
      run_frame(0, 1'b0);

      // Ramp with result backpressure
      build_exp();
      rr_pct = 30;
      run_frame(0, 1'b0);

      // Ramp with source gaps
      build_exp();
      rr_pct = 100; amode = 1;
      run_frame(0, 1'b0);

      // Reset at the 40th activation, then a clean frame
      build_exp();
      amode = 0;
      run_frame(40, 1'b0);
      chk("post_abort_weight", conv_weight[4*16 +: 16], 0);
      build_exp();
      rr_pct = 50;
      run_frame(0, 1'b0);

      // Random data with a stray start mid-stream
      for (int i = 0; i < KK; i++) w_arr[i] = $urandom_range(0, 255);
      for (int i = 0; i < NN; i++) a_arr[i] = $urandom_range(0, 255);
      build_exp();
      rr_pct = 60; amode = 2;
      run_frame(0, 1'b1);

      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < KK; i++) w_arr[i] = $urandom_range(0, 255);
         for (int i = 0; i < NN; i++) a_arr[i] = $urandom_range(0, 255);
         build_exp();
         rr_pct = $urandom_range(20, 100);
         amode  = 2;
         run_frame(0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
